// File: rtl/full_subtractor.sv
// full_subtractor: ripple-borrow subtractor computing {Bout, D} = a - b - Bin.
// It also has a capture stage that registers the result when in_valid is
// high, and a saturating counter of captured results that borrowed.
module full_subtractor #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic [WIDTH-1:0] D_q,
   output logic             Bout_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] borrow_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Borrow chain: entry i is the borrow into bit i; the top entry is the borrow-out.
   logic [WIDTH:0] borrow_chain;

   logic [WIDTH-1:0] d_q_reg;
   logic [WIDTH-1:0] d_q_next;
   logic             bout_q_reg;
   logic             bout_q_next;
   logic             out_valid_reg;
   logic             out_valid_next;
   logic [CNT_W-1:0] borrow_cnt_reg;
   logic [CNT_W-1:0] borrow_cnt_next;

   assign borrow_chain[0] = Bin;

   // Each bit is one full-subtractor cell. The borrow ripples from bit 0 upward.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign D[gi]              = a[gi] ^ b[gi] ^ borrow_chain[gi];
         assign borrow_chain[gi+1] = (~a[gi] & b[gi]) |
                                     (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
      end
   endgenerate

   assign Bout = borrow_chain[WIDTH];

   // Next-state logic. The result is captured only when in_valid is high.
   // The counter stops at its maximum value and does not wrap.
   always_comb begin
      d_q_next        = d_q_reg;
      bout_q_next     = bout_q_reg;
      out_valid_next  = in_valid;
      borrow_cnt_next = borrow_cnt_reg;
      if (in_valid) begin
         d_q_next    = D;
         bout_q_next = Bout;
         if (Bout && (borrow_cnt_reg != CNT_MAX)) begin
            borrow_cnt_next = borrow_cnt_reg + CNT_W'(1);
         end
      end
   end

   // State registers. Reset clears them immediately and drops any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q_reg        <= '0;
         bout_q_reg     <= 1'b0;
         out_valid_reg  <= 1'b0;
         borrow_cnt_reg <= '0;
      end else begin
         d_q_reg        <= d_q_next;
         bout_q_reg     <= bout_q_next;
         out_valid_reg  <= out_valid_next;
         borrow_cnt_reg <= borrow_cnt_next;
      end
   end

   assign D_q        = d_q_reg;
   assign Bout_q     = bout_q_reg;
   assign out_valid  = out_valid_reg;
   assign borrow_cnt = borrow_cnt_reg;

endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: directed-vector bench for full_subtractor.
// It drives three instances: WIDTH=1, WIDTH=8, and WIDTH=1 with CNT_W=2.
module tb_full_subtractor;

   logic clk     = 1'b0;
   logic clk_run = 1'b0;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   // WIDTH=1 instance signals
   logic       w1_a, w1_b, w1_bin, w1_vld;
   logic       w1_d, w1_bout, w1_dq, w1_boutq, w1_ovld;
   logic [15:0] w1_cnt;
   // WIDTH=8 instance signals
   logic [7:0] w8_a, w8_b, w8_d, w8_dq;
   logic       w8_bin, w8_vld, w8_bout, w8_boutq, w8_ovld;
   logic [15:0] w8_cnt;
   // CNT_W=2 instance signals
   logic       c2_a, c2_b, c2_bin, c2_vld;
   logic       c2_d, c2_bout, c2_dq, c2_boutq, c2_ovld;
   logic [1:0] c2_cnt;

   full_subtractor #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .clk(clk), .rst_n(rst_n), .a(w1_a), .b(w1_b), .Bin(w1_bin), .in_valid(w1_vld),
      .D(w1_d), .Bout(w1_bout), .D_q(w1_dq), .Bout_q(w1_boutq),
      .out_valid(w1_ovld), .borrow_cnt(w1_cnt));

   full_subtractor #(.WIDTH(8), .CNT_W(16)) u_w8 (
      .clk(clk), .rst_n(rst_n), .a(w8_a), .b(w8_b), .Bin(w8_bin), .in_valid(w8_vld),
      .D(w8_d), .Bout(w8_bout), .D_q(w8_dq), .Bout_q(w8_boutq),
      .out_valid(w8_ovld), .borrow_cnt(w8_cnt));

   full_subtractor #(.WIDTH(1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .a(c2_a), .b(c2_b), .Bin(c2_bin), .in_valid(c2_vld),
      .D(c2_d), .Bout(c2_bout), .D_q(c2_dq), .Bout_q(c2_boutq),
      .out_valid(c2_ovld), .borrow_cnt(c2_cnt));

   // Clock toggles only once the bench enables it, so the combinational phase sees an idle clk.
   always #5 if (clk_run) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Watchdog so that the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Exhaustive WIDTH=1 expectations, indexed by {a,b,Bin}
   logic [7:0] exp_d1    = 8'b1001_0110;  // bit i = D for vector i
   logic [7:0] exp_bout1 = 8'b1000_1110;  // bit i = Bout for vector i

   // WIDTH=8 directed vectors: a, b, Bin, expected D, expected Bout
   logic [7:0] v8_a   [6] = '{8'h05, 8'h00, 8'h80, 8'h10, 8'hFF, 8'hFF};
   logic [7:0] v8_b   [6] = '{8'h03, 8'h00, 8'h01, 8'h20, 8'hFF, 8'h00};
   logic       v8_bin [6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
   logic [7:0] v8_d   [6] = '{8'h01, 8'hFF, 8'h7F, 8'hF0, 8'hFF, 8'hFE};
   logic       v8_bo  [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

   logic [1:0] exp_cnt2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      rst_n = 1'b0;
      {w1_a, w1_b, w1_bin, w1_vld} = '0;
      {w8_a, w8_b, w8_bin, w8_vld} = '0;
      {c2_a, c2_b, c2_bin, c2_vld} = '0;
      #1;
      // Reset state
      check("rst_w1_dq",   32'(w1_dq),    32'd0);
      check("rst_w1_bq",   32'(w1_boutq), 32'd0);
      check("rst_w1_ovld", 32'(w1_ovld),  32'd0);
      check("rst_w1_cnt",  32'(w1_cnt),   32'd0);
      check("rst_w8_dq",   32'(w8_dq),    32'd0);

      // Exhaustive combinational test with an idle clock, during reset
      for (int i = 0; i < 8; i++) begin
         {w1_a, w1_b, w1_bin} = 3'(i);
         #1;
         check($sformatf("comb1_%0d_D", i),    32'(w1_d),    32'(exp_d1[i]));
         check($sformatf("comb1_%0d_Bout", i), 32'(w1_bout), 32'(exp_bout1[i]));
      end

      // WIDTH=8 combinational vectors, including wrap-around
      for (int i = 0; i < 6; i++) begin
         w8_a = v8_a[i]; w8_b = v8_b[i]; w8_bin = v8_bin[i];
         #1;
         check($sformatf("comb8_%0d_D", i),    32'(w8_d),    32'(v8_d[i]));
         check($sformatf("comb8_%0d_Bout", i), 32'(w8_bout), 32'(v8_bo[i]));
      end

      // Start the clock and release reset between edges
      clk_run = 1'b1;
      tick();
      rst_n = 1'b1;

      // Registered path: capture 1-0-0, then hold
      w1_a = 1'b1; w1_b = 1'b0; w1_bin = 1'b0; w1_vld = 1'b1;
      w8_a = 8'h00; w8_b = 8'h00; w8_bin = 1'b1; w8_vld = 1'b1;
      tick();
      check("reg_cap_dq",   32'(w1_dq),    32'd1);
      check("reg_cap_bq",   32'(w1_boutq), 32'd0);
      check("reg_cap_ovld", 32'(w1_ovld),  32'd1);
      check("reg_cap_cnt",  32'(w1_cnt),   32'd0);
      check("reg8_cap_dq",  32'(w8_dq),    32'hFF);
      check("reg8_cap_bq",  32'(w8_boutq), 32'd1);
      check("reg8_cap_cnt", 32'(w8_cnt),   32'd1);

      w1_vld = 1'b0; w1_a = 1'b0; w1_b = 1'b1;
      w8_vld = 1'b0; w8_a = 8'h05; w8_b = 8'h03;
      tick();
      check("reg_hold_dq",   32'(w1_dq),    32'd1);
      check("reg_hold_bq",   32'(w1_boutq), 32'd0);
      check("reg_hold_ovld", 32'(w1_ovld),  32'd0);
      check("reg8_hold_dq",  32'(w8_dq),    32'hFF);
      check("reg8_hold_cnt", 32'(w8_cnt),   32'd1);

      // Unknown inputs while in_valid=0 must not disturb any register
      w1_a = 1'bx; w1_b = 1'bx; w1_bin = 1'bx;
      tick();
      check("xin_dq",   32'(w1_dq),    32'd1);
      check("xin_bq",   32'(w1_boutq), 32'd0);
      check("xin_ovld", 32'(w1_ovld),  32'd0);
      check("xin_cnt",  32'(w1_cnt),   32'd0);

      // Capture a borrowing result: 0-1-0 -> D=1, Bout=1
      w1_a = 1'b0; w1_b = 1'b1; w1_bin = 1'b0; w1_vld = 1'b1;
      tick();
      check("reg_brw_dq",  32'(w1_dq),    32'd1);
      check("reg_brw_bq",  32'(w1_boutq), 32'd1);
      check("reg_brw_cnt", 32'(w1_cnt),   32'd1);
      w1_vld = 1'b0;

      // Saturating counter with CNT_W=2
      c2_a = 1'b0; c2_b = 1'b1; c2_bin = 1'b0; c2_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("cnt2_step%0d", i), 32'(c2_cnt), 32'(exp_cnt2[i]));
      end
      check("cnt2_ovld", 32'(c2_ovld), 32'd1);

      // Asynchronous reset mid-cycle: registers clear before the next edge
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dq",   32'(c2_dq),    32'd0);
      check("arst_bq",   32'(c2_boutq), 32'd0);
      check("arst_ovld", 32'(c2_ovld),  32'd0);
      check("arst_cnt",  32'(c2_cnt),   32'd0);
      check("arst_D",    32'(c2_d),     32'd1);
      check("arst_Bout", 32'(c2_bout),  32'd1);
      c2_a = 1'b1; c2_b = 1'b0;
      #1;
      check("arst_D2",    32'(c2_d),    32'd1);
      check("arst_Bout2", 32'(c2_bout), 32'd0);

      // Release reset between edges and capture 1-1-1 on the next edge
      rst_n = 1'b1;
      c2_a = 1'b1; c2_b = 1'b1; c2_bin = 1'b1; c2_vld = 1'b1;
      tick();
      check("rel_dq",   32'(c2_dq),    32'd1);
      check("rel_bq",   32'(c2_boutq), 32'd1);
      check("rel_ovld", 32'(c2_ovld),  32'd1);
      check("rel_cnt",  32'(c2_cnt),   32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
